// File: rtl/mem_stage.sv
// Pipeline memory stage: loads/stores over a req/gnt/rvalid bus with byte-lane steering and extension.
// Optional alignment trap is built when MEM_STAGE_MISALIGN_CHK_EN is defined.
module mem_stage #(
   parameter int unsigned DMEM_AW = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic               flush,
   input  logic [3:0]         op_type,
   input  logic [4:0]         op_spec,
   input  logic [4:0]         rd_ind,
   input  logic [31:0]        rd_dat,
   input  logic [31:0]        mem_addr,
   input  logic [31:0]        mem_dat,
   input  logic               mem_read_en,
   input  logic               mem_write_en,
   output logic               stall_out,
   output logic               dmem_req,
   output logic               dmem_we,
   output logic [DMEM_AW-1:0] dmem_addr,
   output logic [3:0]         dmem_be,
   output logic [31:0]        dmem_wdata,
   input  logic               dmem_gnt,
   input  logic               dmem_rvalid,
   input  logic [31:0]        dmem_rdata,
   output logic               valid_out,
   output logic [4:0]         rd_ind_out,
   output logic [31:0]        rd_dat_out,
   output logic               rd_we_out,
   output logic               misalign_out
);
   localparam int unsigned XLEN = 32;

   localparam logic [3:0] OP_ALU = 4'd0;
   localparam logic [3:0] OP_MEM = 4'd1;
   localparam logic [3:0] OP_JMP = 4'd3;
   localparam logic [3:0] OP_UI  = 4'd4;

   localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3;
   localparam logic [2:0] LHU = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

   state_e              state_q;
   logic                req_q, we_q;
   logic [DMEM_AW-1:0]  addr_q;
   logic [3:0]          be_q;
   logic [XLEN-1:0]     wdata_q;
   logic                valid_q, rd_we_q, misalign_q;
   logic [4:0]          rd_ind_q, pend_rd_q;
   logic [XLEN-1:0]     rd_dat_q;
   logic [2:0]          spec_q;
   logic [1:0]          off_q;

   logic                is_mem_c, wb_en_c, misalign_c;
   logic [1:0]          off_c;
   logic [3:0]          be_c;
   logic [XLEN-1:0]     wdata_c, sel_c, load_c;
   logic                unused_c;

   assign is_mem_c = (op_type == OP_MEM) && (op_spec <= 5'd7);
   assign wb_en_c  = ((op_type == OP_ALU) || (op_type == OP_JMP) || (op_type == OP_UI))
                     && (rd_ind != 5'd0);
   // Bus direction comes from mem_write_en alone; the read strobe is redundant here.
   assign unused_c = mem_read_en;

   // Lane offset, byte enables and replicated write data for the incoming op.
   always_comb begin
      off_c   = 2'b00;
      be_c    = 4'b1111;
      wdata_c = '0;
      case (op_spec[2:0])
         LB, LBU: off_c = mem_addr[1:0];
         LH, LHU: off_c = {mem_addr[1], 1'b0};
         SB: begin
            off_c   = mem_addr[1:0];
            be_c    = 4'b0001 << mem_addr[1:0];
            wdata_c = {4{mem_dat[7:0]}};
         end
         SH: begin
            off_c   = {mem_addr[1], 1'b0};
            be_c    = mem_addr[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{mem_dat[15:0]}};
         end
         SW:      wdata_c = mem_dat;
         default: ;
      endcase
   end

`ifdef MEM_STAGE_MISALIGN_CHK_EN
   always_comb begin
      misalign_c = 1'b0;
      case (op_spec[2:0])
         LH, LHU, SH: misalign_c = mem_addr[0];
         LW, SW:      misalign_c = |mem_addr[1:0];
         default:     ;
      endcase
   end
`else
   assign misalign_c = 1'b0;
`endif

   // Right-align the addressed lane, then sign/zero extend.
   always_comb begin
      sel_c  = dmem_rdata >> {off_q, 3'b000};
      load_c = sel_c;
      case (spec_q)
         LB:      load_c = {{24{sel_c[7]}}, sel_c[7:0]};
         LH:      load_c = {{16{sel_c[15]}}, sel_c[15:0]};
         LBU:     load_c = {24'h0, sel_c[7:0]};
         LHU:     load_c = {16'h0, sel_c[15:0]};
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         be_q       <= '0;
         wdata_q    <= '0;
         valid_q    <= 1'b0;
         rd_we_q    <= 1'b0;
         misalign_q <= 1'b0;
         rd_ind_q   <= '0;
         rd_dat_q   <= '0;
         pend_rd_q  <= '0;
         spec_q     <= '0;
         off_q      <= '0;
      end else begin
         valid_q    <= 1'b0;
         rd_we_q    <= 1'b0;
         misalign_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (in_valid && !flush) begin
                  if (!is_mem_c) begin
                     valid_q  <= 1'b1;
                     rd_ind_q <= rd_ind;
                     rd_dat_q <= rd_dat;
                     rd_we_q  <= wb_en_c;
                  end else if (misalign_c) begin
                     valid_q    <= 1'b1;
                     misalign_q <= 1'b1;
                     rd_ind_q   <= rd_ind;
                  end else begin
                     spec_q    <= op_spec[2:0];
                     pend_rd_q <= rd_ind;
                     off_q     <= off_c;
                     req_q     <= 1'b1;
                     we_q      <= mem_write_en;
                     addr_q    <= DMEM_AW'({mem_addr[31:2], 2'b00});
                     be_q      <= be_c;
                     wdata_q   <= wdata_c;
                     state_q   <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (dmem_gnt) begin
                  req_q <= 1'b0;
                  if (we_q) begin
                     valid_q  <= 1'b1;
                     rd_ind_q <= pend_rd_q;
                     state_q  <= S_IDLE;
                  end else begin
                     state_q <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (dmem_rvalid) begin
                  valid_q  <= 1'b1;
                  rd_ind_q <= pend_rd_q;
                  rd_dat_q <= load_c;
                  rd_we_q  <= (pend_rd_q != 5'd0);
                  state_q  <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign stall_out    = (state_q != S_IDLE);
   assign dmem_req     = req_q;
   assign dmem_we      = we_q;
   assign dmem_addr    = addr_q;
   assign dmem_be      = be_q;
   assign dmem_wdata   = wdata_q;
   assign valid_out    = valid_q;
   assign rd_ind_out   = rd_ind_q;
   assign rd_dat_out   = rd_dat_q;
   assign rd_we_out    = rd_we_q;
   assign misalign_out = misalign_q;

endmodule
